// File: rtl/frame_pkg.sv
// Shared constants for the double-buffered frame store (reader and writer sides).
// Bank base addresses and the read-controller state encoding live here.
package frame_pkg;

  localparam int H_RES        = 640;
  localparam int V_RES        = 480;
  localparam int FRAME_PIXELS = H_RES * V_RES;
  localparam int BANK1_BASE   = FRAME_PIXELS;

  localparam int CNT_W = 19;
  localparam int X_W   = 10;
  localparam int Y_W   = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_FRAME,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } rd_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO: dout always presents the head entry while not empty.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        din,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              wr_ok, rd_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign count = count_q;
  assign wr_ok = wr_en & ~full;
  assign rd_ok = rd_en & ~empty;
  assign dout  = mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
    if (wr_ok && !rd_ok) count_d = count_q + (AW+1)'(1);
    else if (!wr_ok && rd_ok) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage has no reset; occupancy is governed entirely by the pointers.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/frame_reader.sv
// Read-side frame store controller: issues credit-limited sequential SDRAM reads
// over one bank and streams returned pixels in raster order with coordinates and markers.
module frame_reader #(
  parameter int H_RES      = frame_pkg::H_RES,
  parameter int V_RES      = frame_pkg::V_RES,
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 23,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              bank,
  input  logic              frame_ready,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_gnt,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [DATA_W-1:0] pix_data,
  output logic [9:0]        pix_x,
  output logic [8:0]        pix_y,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic              pix_eof,
  output logic              busy,
  output logic              done
);

  import frame_pkg::*;

  localparam int FRAME_PX = H_RES * V_RES;
  localparam int AW       = $clog2(FIFO_DEPTH);

  rd_state_t         state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  req_cnt_q, req_cnt_d;
  logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
  logic [AW:0]       outst_q, outst_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;

  logic [DATA_W-1:0] fifo_dout;
  logic [AW:0]       fifo_count;
  logic              fifo_empty, fifo_full;
  logic              fifo_wr, fifo_rd;
  logic              active, credit_ok, grant, xfer;
  logic              last_req, last_out;

  // Outstanding reads plus buffered pixels never exceed the FIFO depth, so every
  // return is guaranteed a slot. The sum can only shrink while a request waits for
  // its grant, which keeps rd_req stable until accepted.
  assign credit_ok = ({1'b0, outst_q} + {1'b0, fifo_count}) < (AW+2)'(FIFO_DEPTH);
  assign active    = (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign rd_req    = (state_q == ST_READ) && credit_ok;
  assign rd_addr   = rd_req ? (base_q + ADDR_W'(req_cnt_q)) : '0;
  assign grant     = rd_req & rd_gnt;
  assign fifo_wr   = rd_valid & active & ~fifo_full;
  assign pix_valid = ~fifo_empty;
  assign xfer      = pix_valid & pix_ready;
  assign fifo_rd   = xfer;
  assign last_req  = (req_cnt_q == CNT_W'(FRAME_PX - 1));
  assign last_out  = (out_cnt_q == CNT_W'(FRAME_PX - 1));

  assign pix_data  = pix_valid ? fifo_dout : '0;
  assign pix_x     = pix_valid ? x_q : '0;
  assign pix_y     = pix_valid ? y_q : '0;
  assign pix_sof   = pix_valid && (x_q == '0) && (y_q == '0);
  assign pix_eol   = pix_valid && (x_q == X_W'(H_RES - 1));
  assign pix_eof   = pix_valid && last_out;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr_en (fifo_wr),
    .din   (rd_data),
    .rd_en (fifo_rd),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    req_cnt_d = req_cnt_q;
    out_cnt_d = out_cnt_q;
    outst_d   = outst_q;
    x_d       = x_q;
    y_d       = y_q;

    if (grant && !fifo_wr) outst_d = outst_q + (AW+1)'(1);
    else if (!grant && fifo_wr) outst_d = outst_q - (AW+1)'(1);

    if (grant) req_cnt_d = req_cnt_q + CNT_W'(1);

    if (xfer) begin
      out_cnt_d = out_cnt_q + CNT_W'(1);
      if (x_q == X_W'(H_RES - 1)) begin
        x_d = '0;
        y_d = y_q + Y_W'(1);
      end else begin
        x_d = x_q + X_W'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        req_cnt_d = '0;
        out_cnt_d = '0;
        outst_d   = '0;
        x_d       = '0;
        y_d       = '0;
        if (start) begin
          base_d  = bank ? ADDR_W'(FRAME_PX) : '0;
          state_d = ST_WAIT_FRAME;
        end
      end
      ST_WAIT_FRAME: begin
        if (frame_ready) state_d = ST_READ;
      end
      ST_READ: begin
        if (grant && last_req) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (xfer && last_out) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      base_q    <= '0;
      req_cnt_q <= '0;
      out_cnt_q <= '0;
      outst_q   <= '0;
      x_q       <= '0;
      y_q       <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      req_cnt_q <= req_cnt_d;
      out_cnt_q <= out_cnt_d;
      outst_q   <= outst_d;
      x_q       <= x_d;
      y_q       <= y_d;
    end
  end

endmodule

// File: tb/tb_frame_reader.sv
// Directed bench for frame_reader on a reduced 16x8 frame, with an SDRAM return model
// and a pixel scoreboard filled at grant time and drained at each output transfer.
module tb_frame_reader;

  localparam int H     = 16;
  localparam int V     = 8;
  localparam int FRAME = H * V;
  localparam int DEPTH = 8;
  localparam int AW    = 23;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          bank = 1'b0;
  logic          frame_ready = 1'b0;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_gnt = 1'b0;
  logic          rd_valid = 1'b0;
  logic [15:0]   rd_data = '0;
  logic          pix_valid;
  logic          pix_ready = 1'b0;
  logic [15:0]   pix_data;
  logic [9:0]    pix_x;
  logic [8:0]    pix_y;
  logic          pix_sof, pix_eol, pix_eof, busy, done;

  frame_reader #(
    .H_RES(H), .V_RES(V), .DATA_W(16), .ADDR_W(AW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .bank(bank), .frame_ready(frame_ready),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid),
    .rd_data(rd_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y), .pix_sof(pix_sof),
    .pix_eol(pix_eol), .pix_eof(pix_eof), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [9:0]  x;
    logic [8:0]  y;
    logic        sof, eol, eof;
  } pix_t;

  typedef struct {
    logic [15:0] d;
    int          due;
  } ret_t;

  pix_t exp_q[$];
  ret_t ret_q[$];

  int tests_run = 0;
  int failed = 0;

  int cyc = 0;
  int lat = 3;
  bit gnt_rand = 0;
  int stall_at = 0, stall_len = 0, stall_cnt = 0;
  bit saw_block = 0;
  bit quiesce = 0, force_rv = 0;
  int exp_base = 0;
  int gcnt = 0, xcnt = 0;
  int sof_cnt = 0, eol_cnt = 0, eof_cnt = 0, done_cnt = 0;
  int last_xfer = -100;
  int first_addr = -1, last_addr = -1;
  int max_inflight = 0;
  bit hold_pending = 0;
  logic [AW-1:0] hold_addr;

  function automatic logic [15:0] mem_word(input logic [AW-1:0] a);
    logic [31:0] t;
    t = 32'(a) * 32'd40503 + 32'd7;
    return t[15:0] ^ 16'h3C5A;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // SDRAM responder and output checker; all inputs change on the falling edge.
  always @(negedge clk) begin
    int inflight;
    pix_t e;
    ret_t r;
    int idx;
    cyc++;
    if (quiesce) begin
      rd_gnt    = 1'b0;
      pix_ready = 1'b1;
      rd_valid  = force_rv;
      rd_data   = 16'hBEEF;
      hold_pending = 0;
    end else begin
      inflight = gcnt - xcnt;
      if (inflight > max_inflight) max_inflight = inflight;

      rd_gnt = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;

      if (stall_len > 0 && xcnt >= stall_at && stall_cnt < stall_len) begin
        pix_ready = 1'b0;
        stall_cnt++;
        if (stall_cnt > 30 && !rd_req) saw_block = 1;
      end else begin
        pix_ready = 1'b1;
      end

      if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
        r = ret_q.pop_front();
        rd_valid = 1'b1;
        rd_data  = r.d;
      end else begin
        rd_valid = 1'b0;
      end

      if (hold_pending) begin
        check("addr_hold", {rd_req, 40'(rd_addr)}, {1'b1, 40'(hold_addr)});
        hold_pending = 0;
      end

      if (rd_req) begin
        if (gcnt >= FRAME) check("extra_req", 1, 0);
        if (rd_gnt) begin
          check("rd_addr", 64'(rd_addr), 64'(exp_base + gcnt));
          if (gcnt == 0) first_addr = int'(rd_addr);
          last_addr = int'(rd_addr);
          r.d   = mem_word(rd_addr);
          r.due = cyc + lat;
          ret_q.push_back(r);
          idx   = gcnt;
          e.d   = mem_word(AW'(exp_base + idx));
          e.x   = 10'(idx % H);
          e.y   = 9'(idx / H);
          e.sof = (idx == 0);
          e.eol = ((idx % H) == H - 1);
          e.eof = (idx == FRAME - 1);
          exp_q.push_back(e);
          gcnt++;
        end else begin
          hold_pending = 1;
          hold_addr    = rd_addr;
        end
      end

      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pixel", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("pixel", {pix_data, pix_x, pix_y, pix_sof, pix_eol, pix_eof},
                {e.d, e.x, e.y, e.sof, e.eol, e.eof});
        end
        if (pix_sof) sof_cnt++;
        if (pix_eol) eol_cnt++;
        if (pix_eof) eof_cnt++;
        xcnt++;
        if (xcnt == FRAME) last_xfer = cyc;
      end

      if (done) begin
        done_cnt++;
        check("done_timing", 64'(cyc), 64'(last_xfer + 1));
      end
    end
  end

  task automatic clear_model(input bit bk, input int lt, input bit rg, input int sat, input int slen);
    lat = lt; gnt_rand = rg; stall_at = sat; stall_len = slen; stall_cnt = 0; saw_block = 0;
    exp_base = bk ? FRAME : 0;
    gcnt = 0; xcnt = 0; sof_cnt = 0; eol_cnt = 0; eof_cnt = 0; done_cnt = 0;
    last_xfer = -100; first_addr = -1; last_addr = -1; max_inflight = 0; hold_pending = 0;
    exp_q.delete();
    ret_q.delete();
  endtask

  task automatic run_frame(input string name, input bit bk, input int lt, input bit rg,
                           input int frd, input int sat, input int slen);
    int bad;
    @(negedge clk);
    clear_model(bk, lt, rg, sat, slen);
    frame_ready = (frd == 0);
    bank  = bk;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, ":busy_after_start"}, 64'(busy), 1);
    bad = 0;
    for (int i = 0; i < frd; i++) begin
      if (rd_req || !busy) bad++;
      @(negedge clk);
    end
    if (frd > 0) begin
      check({name, ":wait_frame_quiet"}, 64'(bad), 0);
      frame_ready = 1'b1;
    end
    for (int i = 0; i < 200 && gcnt == 0; i++) @(negedge clk);
    // Drop frame_ready and fire a stray start once reading is under way.
    frame_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5000 && done_cnt == 0; i++) @(negedge clk);
    check({name, ":done_seen"}, 64'(done_cnt > 0), 1);
    repeat (3) @(negedge clk);
    check({name, ":done_once"}, 64'(done_cnt), 1);
    check({name, ":idle_after"}, 64'(busy), 0);
    check({name, ":req_count"}, 64'(gcnt), 64'(FRAME));
    check({name, ":pix_count"}, 64'(xcnt), 64'(FRAME));
    check({name, ":first_addr"}, 64'(first_addr), 64'(exp_base));
    check({name, ":last_addr"}, 64'(last_addr), 64'(exp_base + FRAME - 1));
    check({name, ":sof_count"}, 64'(sof_cnt), 1);
    check({name, ":eol_count"}, 64'(eol_cnt), 64'(V));
    check({name, ":eof_count"}, 64'(eof_cnt), 1);
    check({name, ":credit_bound"}, 64'(max_inflight <= DEPTH), 1);
    if (slen > 0) check({name, ":req_stalled"}, 64'(saw_block), 1);
    $display("[TB] frame %s bank=%0d lat=%0d reqs=%0d pixels=%0d max_inflight=%0d",
             name, bk, lt, gcnt, xcnt, max_inflight);
  endtask

  initial begin
    int bad;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {rd_req, rd_addr, pix_valid, pix_x, pix_y, pix_sof, pix_eol, pix_eof, busy, done}, '0);
    reset = 1'b1;
    $display("[TB] reset released");

    run_frame("bank0", 1'b0, 3, 1'b0, 0, 0, 0);
    run_frame("bank1", 1'b1, 3, 1'b0, 0, 0, 0);
    run_frame("late_ready", 1'b0, 3, 1'b0, 50, 0, 0);
    run_frame("backpressure", 1'b1, 5, 1'b0, 0, 40, 100);
    run_frame("random_gnt", 1'b0, 4, 1'b1, 0, 0, 0);

    // Mid-frame reset with returns still in flight.
    @(negedge clk);
    clear_model(1'b0, 5, 1'b0, 0, 0);
    frame_ready = 1'b1;
    bank  = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2000 && xcnt < 60; i++) @(negedge clk);
    check("reset_point_reached", 64'(xcnt >= 60), 1);
    quiesce = 1;
    reset = 1'b0;
    @(negedge clk);
    check("midframe_reset_outputs",
          {rd_req, rd_addr, pix_valid, pix_x, pix_y, pix_sof, pix_eol, pix_eof, busy, done}, '0);
    @(negedge clk);
    reset = 1'b1;
    force_rv = 1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (pix_valid || busy) bad++;
    end
    force_rv = 0;
    @(negedge clk);
    if (pix_valid || busy) bad++;
    check("stale_return_ignored", 64'(bad), 0);
    quiesce = 0;
    $display("[TB] mid-frame reset at pixel %0d, stale returns injected", xcnt);

    run_frame("after_reset", 1'b1, 3, 1'b0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
